// File: rtl/lsu_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl_if
//   Word-aligned data-memory bus with a req/gnt address phase and an rvalid
//   read-data phase.
//
//   master (controller side):
//     out bus_req     request, held until bus_gnt
//     out bus_we      1 = write, 0 = read
//     out bus_addr    word-aligned byte address
//     out bus_be      byte enables
//     out bus_wdata   store data replicated across byte lanes
//     in  bus_gnt     request accepted this cycle
//     in  bus_rvalid  read data valid (never in the same cycle as its gnt)
//     in  bus_rdata   read word
//   slave (memory side): same signals, opposite directions.
// ---------------------------------------------------------------------------
interface lsu_bus_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
//   Data-memory bus controller downstream of the LSU. Converts one load or
//   store from the execute stage into a single bus transaction, stalls the
//   pipeline until it completes and returns extended load data.
//
//   Parameters
//     TIMEOUT_CYCLES  max cycles in REQ+WAIT_R before abort (0 = no timeout)
//     CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
//   Ports
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     i_mem_addr      byte address
//     i_mem_wdata     store data, value in the low bits
//     i_mem_we        store request (wins if i_mem_re is also set)
//     i_mem_re        load request
//     i_funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//     o_stall         hold upstream; inputs are stable while high
//     o_load_data     extended load result, 0 unless o_load_valid
//     o_load_valid    1-cycle pulse, load completed
//     o_access_err    1-cycle pulse, misaligned/illegal access, no bus cycle
//     o_bus_err       1-cycle pulse, access aborted by timeout
//     bus             lsu_bus_ctrl_if master modport
// ---------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          i_mem_addr,
    input  logic [31:0]          i_mem_wdata,
    input  logic                 i_mem_we,
    input  logic                 i_mem_re,
    input  logic [2:0]           i_funct3,
    output logic                 o_stall,
    output logic [31:0]          o_load_data,
    output logic                 o_load_valid,
    output logic                 o_access_err,
    output logic                 o_bus_err,
    lsu_bus_ctrl_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    // Timeout fires in the last allowed cycle, so REQ+WAIT_R never exceeds
    // TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;
    logic               r_bus_req;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [3:0]         r_bus_be;
    logic [31:0]        r_bus_wdata;

    logic               w_req;
    logic               w_legal;
    logic               w_align_ok;
    logic               w_f3_ok;
    logic               w_capture;
    logic               w_active;
    logic               w_done;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shift;
    logic [31:0]        w_ext;

    // ------------------------------------------------------------------
    // Request decode: legality, byte enables, lane replication
    // ------------------------------------------------------------------
    assign w_req = i_mem_we | i_mem_re;

    always_comb begin
        w_align_ok = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = i_mem_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_align_ok = 1'b1;
                w_be       = 4'b0001 << i_mem_addr[1:0];
                w_wdata    = {4{i_mem_wdata[7:0]}};
            end
            2'b01: begin
                w_align_ok = ~i_mem_addr[0];
                w_be       = 4'b0011 << i_mem_addr[1:0];
                w_wdata    = {2{i_mem_wdata[15:0]}};
            end
            2'b10: begin
                w_align_ok = (i_mem_addr[1:0] == 2'b00);
                w_be       = 4'b1111;
                w_wdata    = i_mem_wdata;
            end
            default: begin
                w_align_ok = 1'b0;
            end
        endcase
    end

    // Stores must be signed-size codes; loads reject 011 and 11x.
    assign w_f3_ok = i_mem_we ? (~i_funct3[2] && (i_funct3[1:0] != 2'b11))
                              : ((i_funct3[1:0] != 2'b11) && (i_funct3 != 3'b110));
    assign w_legal = w_align_ok & w_f3_ok;

    assign w_capture = (r_state == ST_IDLE) & w_req & w_legal;
    assign w_active  = (r_state == ST_REQ) | (r_state == ST_WAIT_R);

    // Completion: granted store, or read data returned.
    assign w_done = ((r_state == ST_REQ) & bus.bus_gnt & r_bus_we)
                  | ((r_state == ST_WAIT_R) & bus.bus_rvalid);

    // Completion in the last allowed cycle takes priority over the abort.
    assign w_timeout = TO_EN & w_active & (r_cnt == TO_LAST) & ~w_done;

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    assign w_shift = bus.bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shift;
        case (r_f3)
            3'b000:  w_ext = {{24{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Pulses and stall are gated by rst_n so they fall immediately on reset,
    // even if the upstream request is still asserted.
    assign o_load_valid = rst_n & (r_state == ST_WAIT_R) & bus.bus_rvalid;
    assign o_load_data  = o_load_valid ? w_ext : 32'd0;
    assign o_access_err = rst_n & (r_state == ST_IDLE) & w_req & ~w_legal;
    assign o_bus_err    = rst_n & w_timeout;
    assign o_stall      = rst_n & (w_capture | (w_active & ~w_done & ~w_timeout));

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;

    // ------------------------------------------------------------------
    // FSM with registered bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_off       <= 2'b00;
            r_f3        <= 3'b000;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_state     <= ST_REQ;
                        r_cnt       <= '0;
                        r_off       <= i_mem_addr[1:0];
                        r_f3        <= i_funct3;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_we;
                        r_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (bus.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= r_bus_we ? ST_IDLE : ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.bus_rvalid || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    lsu_bus_ctrl_if bus_if ();

    lsu_bus_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mem_addr   (mem_addr),
        .i_mem_wdata  (mem_wdata),
        .i_mem_we     (mem_we),
        .i_mem_re     (mem_re),
        .i_funct3     (funct3),
        .o_stall      (stall),
        .o_load_data  (load_data),
        .o_load_valid (load_valid),
        .o_access_err (access_err),
        .o_bus_err    (bus_err),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Zero-wait load: capture, gnt in first REQ cycle, rvalid the next cycle.
    task automatic load_zw(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
        mem_addr = a; funct3 = f3; mem_re = 1'b1; mem_we = 1'b0;
        #1 chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
        tick();
        bus_if.bus_gnt = 1'b1;
        #1;
        chk({tag, "_req"},      32'(bus_if.bus_req), 32'd1);
        chk({tag, "_addr"},     bus_if.bus_addr, {a[31:2], 2'b00});
        chk({tag, "_be"},       32'(bus_if.bus_be), 32'(be));
        chk({tag, "_stall_c1"}, 32'(stall), 32'd1);
        chk({tag, "_lv_c1"},    32'(load_valid), 32'd0);
        tick();
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rd;
        #1;
        chk({tag, "_lv"},       32'(load_valid), 32'd1);
        chk({tag, "_data"},     load_data, exp);
        chk({tag, "_stall_c2"}, 32'(stall), 32'd0);
        chk({tag, "_req_c2"},   32'(bus_if.bus_req), 32'd0);
        tick();
        mem_re = 1'b0; bus_if.bus_rvalid = 1'b0;
        #1;
        chk({tag, "_lv_end"},   32'(load_valid), 32'd0);
        chk({tag, "_data_end"}, load_data, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_we = 1'b0; mem_re = 1'b0; funct3 = 3'b000;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req",   32'(bus_if.bus_req), 32'd0);
        chk("rst_lv",    32'(load_valid), 32'd0);
        chk("rst_aerr",  32'(access_err), 32'd0);
        chk("rst_berr",  32'(bus_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // rvalid while idle is ignored
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h12345678;
        #1 chk("idle_rvalid_lv", 32'(load_valid), 32'd0);
        tick();
        bus_if.bus_rvalid = 1'b0;

        // Loads
        load_zw("lw",  32'h0000_0100, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        load_zw("lb",  32'h0000_0103, 3'b000, 32'h80112233, 4'b1000, 32'hFFFFFF80);
        load_zw("lbu", 32'h0000_0103, 3'b100, 32'h80112233, 4'b1000, 32'h00000080);
        load_zw("lb1", 32'h0000_0101, 3'b000, 32'h80112233, 4'b0010, 32'h00000022);
        load_zw("lh",  32'h0000_0102, 3'b001, 32'h80112233, 4'b1100, 32'hFFFF8011);
        load_zw("lhu", 32'h0000_0102, 3'b101, 32'h80112233, 4'b1100, 32'h00008011);

        // SH with gnt delayed 3 cycles; gnt lands in the last allowed cycle
        tick();
        mem_addr = 32'h0000_0202; mem_wdata = 32'h0000ABCD; funct3 = 3'b001; mem_we = 1'b1;
        #1 chk("sh_stall_c0", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("sh_req_wait",   32'(bus_if.bus_req), 32'd1);
            chk("sh_stall_wait", 32'(stall), 32'd1);
        end
        tick();
        bus_if.bus_gnt = 1'b1;
        #1;
        chk("sh_req_gnt", 32'(bus_if.bus_req), 32'd1);
        chk("sh_we",      32'(bus_if.bus_we), 32'd1);
        chk("sh_addr",    bus_if.bus_addr, 32'h0000_0200);
        chk("sh_be",      32'(bus_if.bus_be), 32'h0000000C);
        chk("sh_wdata",   bus_if.bus_wdata, 32'hABCDABCD);
        chk("sh_stall",   32'(stall), 32'd0);
        chk("sh_berr",    32'(bus_err), 32'd0);
        tick();
        bus_if.bus_gnt = 1'b0; mem_we = 1'b0;
        #1;
        chk("sh_req_end",  32'(bus_if.bus_req), 32'd0);
        chk("sh_berr_end", 32'(bus_err), 32'd0);

        // SB zero-wait
        mem_addr = 32'h0000_0201; mem_wdata = 32'h1234565A; funct3 = 3'b000; mem_we = 1'b1;
        tick();
        bus_if.bus_gnt = 1'b1;
        #1;
        chk("sb_be",    32'(bus_if.bus_be), 32'h00000002);
        chk("sb_wdata", bus_if.bus_wdata, 32'h5A5A5A5A);
        chk("sb_stall", 32'(stall), 32'd0);
        tick();
        bus_if.bus_gnt = 1'b0; mem_we = 1'b0;
        #1 chk("sb_req_end", 32'(bus_if.bus_req), 32'd0);

        // Illegal accesses: access_err, no request, no stall
        mem_addr = 32'h0000_0101; funct3 = 3'b001; mem_re = 1'b1;
        #1;
        chk("lh_mis_aerr",  32'(access_err), 32'd1);
        chk("lh_mis_stall", 32'(stall), 32'd0);
        mem_addr = 32'h0000_0100; funct3 = 3'b011;
        #1 chk("ld_f3_011_aerr", 32'(access_err), 32'd1);
        funct3 = 3'b110;
        #1 chk("ld_f3_110_aerr", 32'(access_err), 32'd1);
        mem_re = 1'b0; mem_we = 1'b1; funct3 = 3'b100;
        #1 chk("st_f3_100_aerr", 32'(access_err), 32'd1);
        mem_addr = 32'h0000_0102; funct3 = 3'b010;
        #1 chk("sw_mis_aerr", 32'(access_err), 32'd1);
        tick();
        mem_we = 1'b0;
        #1;
        chk("illegal_req",  32'(bus_if.bus_req), 32'd0);
        chk("illegal_aerr", 32'(access_err), 32'd0);

        // Timeout: LW, never granted
        mem_addr = 32'h0000_0300; funct3 = 3'b010; mem_re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("to_req_wait", 32'(bus_if.bus_req), 32'd1);
            chk("to_berr_wait", 32'(bus_err), 32'd0);
        end
        tick();
        #1;
        chk("to_berr",  32'(bus_err), 32'd1);
        chk("to_stall", 32'(stall), 32'd0);
        chk("to_lv",    32'(load_valid), 32'd0);
        tick();
        mem_re = 1'b0;
        #1;
        chk("to_req_after",  32'(bus_if.bus_req), 32'd0);
        chk("to_berr_after", 32'(bus_err), 32'd0);
        chk("to_stall_idle", 32'(stall), 32'd0);
        load_zw("after_to", 32'h0000_0304, 3'b010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        // Reset during REQ drops bus_req immediately
        mem_addr = 32'h0000_0400; funct3 = 3'b010; mem_re = 1'b1;
        tick();
        #1 chk("rq_req", 32'(bus_if.bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rq_rst_req",   32'(bus_if.bus_req), 32'd0);
        chk("rq_rst_stall", 32'(stall), 32'd0);
        tick();
        mem_re = 1'b0; rst_n = 1'b1;
        tick();

        // Reset during WAIT_R; a late rvalid yields no load_valid
        mem_addr = 32'h0000_0500; funct3 = 3'b010; mem_re = 1'b1;
        tick();
        bus_if.bus_gnt = 1'b1;
        tick();
        bus_if.bus_gnt = 1'b0;
        #1 chk("wr_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wr_rst_stall", 32'(stall), 32'd0);
        chk("wr_rst_req",   32'(bus_if.bus_req), 32'd0);
        tick();
        mem_re = 1'b0; rst_n = 1'b1;
        tick();
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h55AA55AA;
        #1;
        chk("wr_late_lv",    32'(load_valid), 32'd0);
        chk("wr_late_stall", 32'(stall), 32'd0);
        tick();
        bus_if.bus_rvalid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
